// File: rtl/adc_trigger_capture.sv
// adc_trigger_capture: converts ADC words, edge-triggers with hysteresis and streams a pre-trigger capture on AXI-Stream
module adc_trigger_capture #(
  parameter int ADC_DATA_WIDTH = 14,
  parameter int CHANNELS = 2,
  parameter int PRE_DEPTH = 256,
  parameter int TS_WIDTH = 48,
  parameter int SETTLE = 6
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic [16*CHANNELS-1:0] adc_dat,
  input  logic [2:0] trig_channel,
  input  logic trig_edge,
  input  logic [15:0] trigger_level,
  input  logic [15:0] hysteresis,
  input  logic [15:0] pre_samples,
  input  logic [31:0] post_limit,
  input  logic arm,
  input  logic abort,
  input  logic m_axis_tready,
  output logic m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic m_axis_tlast,
  output logic [2:0] state,
  output logic [TS_WIDTH-1:0] first_trigged,
  output logic [TS_WIDTH-1:0] last_detrigged,
  output logic [31:0] sent_count,
  output logic overflow,
  output logic [16*CHANNELS-1:0] cur_adc
);
  localparam int AW = $clog2(PRE_DEPTH);
  typedef enum logic [2:0] {IDLE, FILL, ARMED, CAPTURE, DRAIN, DONE} state_t;
  state_t st, st_nx;
  logic [16*CHANNELS-1:0] adc_q, conv;
  logic [TS_WIDTH-1:0] cnt, ts1, ts2;
  logic settled, arm_q, ok_trig, arm_rise, start;
  logic [63:0] mem [PRE_DEPTH];
  logic [AW:0] wr, rd, occ;
  logic [AW-1:0] pre_n;
  logic [31:0] post_cnt;
  logic signed [15:0] cur, prev, lvl, lo, hi;
  logic signed [17:0] lo_w, hi_w;
  logic trig, detrig, at_limit, streaming, pop, hs, full_drop, wr_en, trim;
  logic unused_adc;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_conv
    assign conv[16*i +: 16] = {{(17-ADC_DATA_WIDTH){adc_q[16*i+15]}}, ~adc_q[16*i+14 -: ADC_DATA_WIDTH-1]};
  end
  assign unused_adc = ^adc_q;
  always_comb begin
    cur = cur_adc[15:0];
    for (int k = 1; k < CHANNELS; k++)
      cur = (trig_channel == 3'(k)) ? cur_adc[16*k +: 16] : cur;
  end
  assign state = st;
  assign lvl = trigger_level;
  assign arm_rise = arm && !arm_q;
  assign ok_trig = settled || cnt >= TS_WIDTH'(SETTLE);
  assign trig = ok_trig && (trig_edge ? (prev >= lvl && cur < lvl) : (prev <= lvl && cur > lvl));
  assign lo_w = $signed({{2{lvl[15]}}, lvl}) - $signed({2'b00, hysteresis});
  assign hi_w = $signed({{2{lvl[15]}}, lvl}) + $signed({2'b00, hysteresis});
  assign lo = (lo_w < 18'sh38000) ? 16'sh8000 : lo_w[15:0];
  assign hi = (hi_w > 18'sh07fff) ? 16'sh7fff : hi_w[15:0];
  assign detrig = trig_edge ? (cur > hi) : (cur < lo);
  assign pre_n = (pre_samples > 16'(PRE_DEPTH - 1)) ? AW'(PRE_DEPTH - 1) : pre_samples[AW-1:0];
  assign occ = wr - rd;
  assign at_limit = post_limit != '0 && post_cnt + 1'b1 == post_limit;
  assign streaming = st == CAPTURE || st == DRAIN;
  assign pop = streaming && occ != '0 && (!m_axis_tvalid || m_axis_tready);
  assign hs = m_axis_tvalid && m_axis_tready;
  assign full_drop = st == CAPTURE && occ == (AW+1)'(PRE_DEPTH) && !pop;
  assign wr_en = (st == FILL || st == ARMED || st == CAPTURE) && !full_drop;
  assign trim = (st == FILL || (st == ARMED && !trig)) && occ == {1'b0, pre_n};
  assign start = (st == IDLE || st == DONE) && arm_rise && !abort;
  always_comb begin
    st_nx = st;
    case (st)
      IDLE, DONE: st_nx = arm_rise ? FILL : st;
      FILL: st_nx = (occ + 1'b1 >= {1'b0, pre_n}) ? ARMED : FILL;
      ARMED: st_nx = trig ? CAPTURE : ARMED;
      CAPTURE: st_nx = (detrig || at_limit) ? DRAIN : CAPTURE;
      DRAIN: st_nx = (hs && m_axis_tlast) ? DONE : DRAIN;
      default: st_nx = IDLE;
    endcase
    st_nx = abort ? IDLE : st_nx;
  end
  always_ff @(posedge aclk)
    if (wr_en) mem[wr[AW-1:0]] <= {48'(ts2), cur};
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st <= IDLE;
      cnt <= '0;
      ts1 <= '0;
      ts2 <= '0;
      adc_q <= '0;
      cur_adc <= '0;
      prev <= '0;
      settled <= 1'b0;
      arm_q <= 1'b0;
      wr <= '0;
      rd <= '0;
      post_cnt <= '0;
      first_trigged <= '0;
      last_detrigged <= '0;
      sent_count <= '0;
      overflow <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else begin
      st <= st_nx;
      cnt <= cnt + 1'b1;
      ts1 <= cnt;
      ts2 <= ts1;
      adc_q <= adc_dat;
      cur_adc <= conv;
      prev <= cur;
      settled <= ok_trig;
      arm_q <= arm;
      if (abort || start) begin
        wr <= '0;
        rd <= '0;
      end else begin
        wr <= wr_en ? wr + 1'b1 : wr;
        rd <= (pop || trim) ? rd + 1'b1 : rd;
      end
      if (start) begin
        post_cnt <= '0;
        first_trigged <= '0;
        last_detrigged <= '0;
        sent_count <= '0;
        overflow <= 1'b0;
      end else begin
        if (st == ARMED && trig) begin
          first_trigged <= ts2;
          post_cnt <= '0;
        end
        if (st == CAPTURE) begin
          post_cnt <= post_cnt + 1'b1;
          last_detrigged <= detrig ? ts2 : last_detrigged;
          overflow <= overflow || full_drop;
        end
        sent_count <= (hs && sent_count != '1) ? sent_count + 1'b1 : sent_count;
      end
      if (abort) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast <= 1'b0;
      end else if (pop) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata <= mem[rd[AW-1:0]];
        m_axis_tlast <= st == DRAIN && occ == (AW+1)'(1);
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_adc_trigger_capture.sv
// tb_adc_trigger_capture: directed capture scenarios with hand-computed beat counts, samples and status
module tb_adc_trigger_capture;
  logic aclk = 1'b0;
  logic aresetn = 1'b1;
  logic [31:0] adc_dat;
  logic [2:0] trig_channel;
  logic trig_edge;
  logic [15:0] trigger_level, hysteresis, pre_samples;
  logic [31:0] post_limit;
  logic arm, abort, m_axis_tready;
  logic m_axis_tvalid, m_axis_tlast, overflow;
  logic [63:0] m_axis_tdata;
  logic [2:0] state;
  logic [47:0] first_trigged, last_detrigged;
  logic [31:0] sent_count;
  logic [31:0] cur_adc;
  int v0 = -100;
  int v1 = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int dup;
  logic gap;
  logic [64:0] beats [$];
  function automatic logic [15:0] enc(input int v);
    logic [13:0] t;
    t = 14'(v);
    return {t[13], ~t[12:0], 2'b00};
  endfunction
  assign adc_dat = {enc(v1), enc(v0)};
  always #5 aclk = ~aclk;
  adc_trigger_capture dut (
    .aclk(aclk), .aresetn(aresetn), .adc_dat(adc_dat), .trig_channel(trig_channel),
    .trig_edge(trig_edge), .trigger_level(trigger_level), .hysteresis(hysteresis),
    .pre_samples(pre_samples), .post_limit(post_limit), .arm(arm), .abort(abort),
    .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
    .m_axis_tlast(m_axis_tlast), .state(state), .first_trigged(first_trigged),
    .last_detrigged(last_detrigged), .sent_count(sent_count), .overflow(overflow), .cur_adc(cur_adc)
  );
  always @(negedge aclk)
    if (aresetn && m_axis_tvalid && m_axis_tready) beats.push_back({m_axis_tlast, m_axis_tdata});
  function automatic logic [64:0] bt(input int i);
    return (i >= 0 && i < beats.size()) ? beats[i] : 65'bx;
  endfunction
  function automatic logic [47:0] ts_of(input int i);
    logic [64:0] b;
    b = bt(i);
    return b[63:16];
  endfunction
  function automatic logic [15:0] smp(input int i);
    logic [64:0] b;
    b = bt(i);
    return b[15:0];
  endfunction
  function automatic logic lst(input int i);
    logic [64:0] b;
    b = bt(i);
    return b[64];
  endfunction
  function automatic int n_last();
    int n = 0;
    foreach (beats[i]) n += int'(beats[i][64]);
    return n;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic wait_state(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (state !== s && n < max) begin
      tick(1);
      n++;
    end
    check(tag, 64'(state), 64'(s));
  endtask
  task automatic ramp(input int a, input int b);
    for (int v = a; v <= b; v++) begin
      v0 = v;
      tick(1);
    end
  endtask
  task automatic start_cap(input logic e, input int pre, input int post, input int hyst, input logic [2:0] ch);
    trig_edge = e;
    pre_samples = 16'(pre);
    post_limit = 32'(post);
    hysteresis = 16'(hyst);
    trig_channel = ch;
    tick(3);
    beats.delete();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    wait_state(3'd2, 600, "armed");
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    trig_channel = 3'd0;
    trig_edge = 1'b0;
    trigger_level = 16'd0;
    hysteresis = 16'd0;
    pre_samples = 16'd0;
    post_limit = 32'd0;
    arm = 1'b0;
    abort = 1'b0;
    m_axis_tready = 1'b1;
    #1 aresetn = 1'b0;
    tick(3);
    check("rst_state", 64'(state), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_sent", 64'(sent_count), 64'd0);
    check("rst_cur_adc", 64'(cur_adc), 64'd0);
    aresetn = 1'b1;
    tick(3);
    check("conv_neg100", 64'(cur_adc), 64'h0000_FF9C);
    v0 = -8192;
    v1 = 8191;
    tick(2);
    check("conv_extremes", 64'(cur_adc), 64'h1FFF_E000);
    v0 = -100;
    v1 = 0;
    // ramp, pre 4, post 10
    start_cap(1'b0, 4, 10, 1000, 3'd0);
    ramp(-100, 100);
    wait_state(3'd5, 100, "a_done");
    check("a_beats", 64'(beats.size()), 64'd15);
    check("a_first_smp", 64'(smp(0)), 64'hFFFD);
    check("a_last_smp", 64'(smp(14)), 64'h000B);
    check("a_tlast", 64'(lst(14)), 64'd1);
    check("a_n_last", 64'(n_last()), 64'd1);
    check("a_ts_span", 64'(ts_of(14) - ts_of(0)), 64'd14);
    check("a_first_trig", 64'(first_trigged), 64'(ts_of(4)));
    check("a_last_det", 64'(last_detrigged), 64'd0);
    check("a_sent", 64'(sent_count), 64'd15);
    // pre 8, post 16
    v0 = -100;
    start_cap(1'b0, 8, 16, 1000, 3'd0);
    ramp(-100, 100);
    wait_state(3'd5, 100, "b_done");
    check("b_beats", 64'(beats.size()), 64'd25);
    check("b_first_smp", 64'(smp(0)), 64'hFFF9);
    check("b_last_smp", 64'(smp(24)), 64'h0011);
    check("b_tlast", 64'(lst(24)), 64'd1);
    check("b_n_last", 64'(n_last()), 64'd1);
    check("b_sent", 64'(sent_count), 64'd25);
    // no pre-trigger samples
    v0 = -100;
    start_cap(1'b0, 0, 3, 1000, 3'd0);
    ramp(-100, 100);
    wait_state(3'd5, 100, "c_done");
    check("c_beats", 64'(beats.size()), 64'd4);
    check("c_first_smp", 64'(smp(0)), 64'h0001);
    check("c_last_smp", 64'(smp(3)), 64'h0004);
    check("c_tlast", 64'(lst(3)), 64'd1);
    // falling edge with noise inside hysteresis, out-of-range channel falls back to 0
    v0 = 5;
    v1 = 3000;
    start_cap(1'b1, 2, 20, 10, 3'd5);
    for (int i = 0; i < 60; i++) begin
      v0 = (i % 2 == 0) ? -5 : 5;
      tick(1);
    end
    wait_state(3'd5, 100, "d_done");
    check("d_beats", 64'(beats.size()), 64'd23);
    check("d_pre_smp", 64'(smp(0)), 64'h0005);
    check("d_trig_smp", 64'(smp(2)), 64'hFFFB);
    check("d_first_trig", 64'(first_trigged), 64'(ts_of(2)));
    check("d_last_det", 64'(last_detrigged), 64'd0);
    check("d_n_last", 64'(n_last()), 64'd1);
    v1 = 0;
    // long backpressure, overflow, then detrigger
    m_axis_tready = 1'b0;
    v0 = -100;
    start_cap(1'b0, 8, 0, 10, 3'd0);
    v0 = 50;
    tick(300);
    v0 = -20;
    m_axis_tready = 1'b1;
    wait_state(3'd5, 800, "e_done");
    dup = 0;
    gap = 1'b0;
    for (int i = 1; i < beats.size(); i++) begin
      if (ts_of(i) <= ts_of(i - 1)) dup++;
      if (ts_of(i) > ts_of(i - 1) + 48'd1) gap = 1'b1;
    end
    check("e_overflow", 64'(overflow), 64'd1);
    check("e_trig_smp", 64'(smp(8)), 64'h0032);
    check("e_first_trig", 64'(first_trigged), 64'(ts_of(8)));
    check("e_last_smp", 64'(smp(beats.size() - 1)), 64'hFFEC);
    check("e_tlast", 64'(lst(beats.size() - 1)), 64'd1);
    check("e_n_last", 64'(n_last()), 64'd1);
    check("e_last_det", 64'(last_detrigged), 64'(ts_of(beats.size() - 1)));
    check("e_no_dup", 64'(dup), 64'd0);
    check("e_ts_gap", 64'(gap), 64'd1);
    check("e_sent", 64'(sent_count), 64'(beats.size()));
    // abort during drain, then a fresh capture
    m_axis_tready = 1'b0;
    v0 = -100;
    start_cap(1'b0, 2, 4, 1000, 3'd0);
    ramp(-100, 100);
    wait_state(3'd4, 50, "f_drain");
    m_axis_tready = 1'b1;
    tick(2);
    m_axis_tready = 1'b0;
    check("f_sent_partial", 64'(sent_count), 64'd2);
    check("f_still_drain", 64'(state), 64'd4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("f_abort_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("f_abort_state", 64'(state), 64'd0);
    m_axis_tready = 1'b1;
    v0 = -100;
    start_cap(1'b0, 2, 4, 1000, 3'd0);
    check("f_sent_restart", 64'(sent_count), 64'd0);
    ramp(-100, 100);
    wait_state(3'd5, 100, "f_done");
    check("f_beats", 64'(beats.size()), 64'd7);
    check("f_first_smp", 64'(smp(0)), 64'hFFFF);
    check("f_sent", 64'(sent_count), 64'd7);
    // asynchronous reset in the middle of a capture
    v0 = -100;
    start_cap(1'b0, 2, 0, 1000, 3'd0);
    ramp(-100, 20);
    wait_state(3'd3, 10, "g_capture");
    aresetn = 1'b0;
    #1;
    check("g_rst_state", 64'(state), 64'd0);
    check("g_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("g_rst_sent", 64'(sent_count), 64'd0);
    check("g_rst_first", 64'(first_trigged), 64'd0);
    check("g_rst_cur_adc", 64'(cur_adc), 64'd0);
    tick(2);
    aresetn = 1'b1;
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
